// File: rtl/mb_entrada_teclado_pkg.sv
// Shared constants for the Multibanco keypad entry path: key codes, field encodings, default maxima, FSM states.
package mb_pkg;

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_OK  = 4'hB;

    localparam logic [1:0] F_PIN = 2'd0;
    localparam logic [1:0] F_VAL = 2'd1;
    localparam logic [1:0] F_COD = 2'd2;

    localparam int PIN_MAX_DEF = 31;
    localparam int VAL_MAX_DEF = 31;
    localparam int COD_MAX_DEF = 63;

    typedef enum logic [1:0] {
        S_PIN = F_PIN,
        S_VAL = F_VAL,
        S_COD = F_COD
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/mb_entrada_teclado_if.sv
// Keypad-to-datapath bundle: key strobe in, committed transaction and display state out.
interface mb_entrada_teclado_if;

    logic       KEY_VALID;
    logic [3:0] KEY;
    logic [4:0] PIN;
    logic [4:0] VAL;
    logic [5:0] COD;
    logic       EN;
    logic       ERR;
    logic [1:0] FIELD;
    logic [6:0] ACC;

    modport master (
        output KEY_VALID, KEY,
        input  PIN, VAL, COD, EN, ERR, FIELD, ACC
    );

    modport slave (
        input  KEY_VALID, KEY,
        output PIN, VAL, COD, EN, ERR, FIELD, ACC
    );

endinterface

// File: rtl/mb_entrada_teclado_acum.sv
// Two-digit decimal accumulator: acc = acc*10 + digit, saturating at two digits.
// One-cycle latency; loads beyond the second digit are dropped silently.
module mb_acum_dec (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       clr,
    input  logic [3:0] digit,
    output logic [6:0] acc,
    output logic [1:0] cnt
);

    logic [6:0] acc_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= 7'd0;
            cnt_q <= 2'd0;
        end else if (load && cnt_q != 2'd2) begin
            // at most 9*10+9 = 99, fits in 7 bits
            acc_q <= acc_q * 7'd10 + {3'b000, digit};
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign acc = acc_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/mb_entrada_teclado.sv
// Keypad entry sequencer: PIN -> VAL -> COD, range-checked, committed with a one-cycle EN strobe.
// Every key takes effect one cycle after its KEY_VALID edge; keys may arrive every cycle.
module mb_entrada_teclado
    import mb_pkg::*;
#(
    parameter int PIN_MAX = PIN_MAX_DEF,
    parameter int VAL_MAX = VAL_MAX_DEF,
    parameter int COD_MAX = COD_MAX_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    mb_entrada_teclado_if.slave bus
);

    state_t     state_q, state_d;
    logic [6:0] acc;
    logic [1:0] cnt;
    logic       acc_load, acc_clr;
    logic [6:0] field_max;
    logic [4:0] sh_pin_q, sh_pin_d, sh_val_q, sh_val_d;
    logic [4:0] pin_q, val_q;
    logic [5:0] cod_q;
    logic       en_q, en_d, err_q, err_d, commit;

    localparam logic [6:0] PIN_MAX_7 = 7'(PIN_MAX);
    localparam logic [6:0] VAL_MAX_7 = 7'(VAL_MAX);
    localparam logic [6:0] COD_MAX_7 = 7'(COD_MAX);

    mb_acum_dec u_acum (
        .clk   (CLK),
        .rst   (RST),
        .load  (acc_load),
        .clr   (acc_clr),
        .digit (bus.KEY),
        .acc   (acc),
        .cnt   (cnt)
    );

    always_comb begin
        case (state_q)
            S_VAL:   field_max = VAL_MAX_7;
            S_COD:   field_max = COD_MAX_7;
            default: field_max = PIN_MAX_7;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_load = 1'b0;
        acc_clr  = 1'b0;
        err_d    = 1'b0;
        en_d     = 1'b0;
        commit   = 1'b0;
        sh_pin_d = sh_pin_q;
        sh_val_d = sh_val_q;
        if (bus.KEY_VALID) begin
            if (is_digit(bus.KEY)) begin
                acc_load = (cnt != 2'd2);
            end else if (bus.KEY == KEY_CLR) begin
                if (cnt != 2'd0) begin
                    acc_clr = 1'b1;
                end else begin
                    case (state_q)
                        S_COD:   state_d = S_VAL;
                        S_VAL:   state_d = S_PIN;
                        default: state_d = S_PIN;
                    endcase
                end
            end else if (bus.KEY == KEY_OK) begin
                if (cnt == 2'd0) begin
                    err_d = 1'b1;
                end else if (acc > field_max) begin
                    err_d   = 1'b1;
                    acc_clr = 1'b1;
                end else begin
                    acc_clr = 1'b1;
                    case (state_q)
                        S_PIN: begin
                            sh_pin_d = acc[4:0];
                            state_d  = S_VAL;
                        end
                        S_VAL: begin
                            sh_val_d = acc[4:0];
                            state_d  = S_COD;
                        end
                        default: begin
                            commit   = 1'b1;
                            en_d     = 1'b1;
                            sh_pin_d = 5'd0;
                            sh_val_d = 5'd0;
                            state_d  = S_PIN;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_PIN;
            sh_pin_q <= 5'd0;
            sh_val_q <= 5'd0;
            pin_q    <= 5'd0;
            val_q    <= 5'd0;
            cod_q    <= 6'd0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_pin_q <= sh_pin_d;
            sh_val_q <= sh_val_d;
            en_q     <= en_d;
            err_q    <= err_d;
            // committed outputs move only together, on a valid COD OK
            if (commit) begin
                pin_q <= sh_pin_q;
                val_q <= sh_val_q;
                cod_q <= acc[5:0];
            end
        end
    end

    assign bus.PIN   = pin_q;
    assign bus.VAL   = val_q;
    assign bus.COD   = cod_q;
    assign bus.EN    = en_q;
    assign bus.ERR   = err_q;
    assign bus.FIELD = state_q;
    assign bus.ACC   = acc;

endmodule

// File: tb/tb_mb_entrada_teclado.sv
// Bench for the keypad entry sequencer: directed scenarios plus a randomized run against a field-level model.
module tb_mb_entrada_teclado;
    import mb_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    mb_entrada_teclado_if bus();

    mb_entrada_teclado #(.PIN_MAX(31), .VAL_MAX(31), .COD_MAX(63)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // model: field index, typed value, digits typed, shadows, committed values
    int m_f, m_acc, m_cnt, m_shp, m_shv, m_pin, m_val, m_cod, m_en, m_err;
    int mx[3] = '{31, 31, 63};

    task automatic model_reset();
        m_f = 0; m_acc = 0; m_cnt = 0; m_shp = 0; m_shv = 0;
        m_pin = 0; m_val = 0; m_cod = 0; m_en = 0; m_err = 0;
    endtask

    task automatic model_key(input int k);
        if (k <= 9) begin
            if (m_cnt < 2) begin
                m_acc = m_acc * 10 + k;
                m_cnt++;
            end
        end else if (k == 10) begin
            if (m_cnt > 0) begin
                m_acc = 0; m_cnt = 0;
            end else if (m_f > 0) begin
                m_f--;
            end
        end else if (k == 11) begin
            if (m_cnt == 0) begin
                m_err = 1;
            end else if (m_acc > mx[m_f]) begin
                m_err = 1; m_acc = 0; m_cnt = 0;
            end else begin
                if (m_f == 0) begin
                    m_shp = m_acc; m_f = 1;
                end else if (m_f == 1) begin
                    m_shv = m_acc; m_f = 2;
                end else begin
                    m_pin = m_shp; m_val = m_shv; m_cod = m_acc; m_en = 1;
                    m_shp = 0; m_shv = 0; m_f = 0;
                end
                m_acc = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic key(input logic [3:0] k);
        @(negedge CLK);
        bus.KEY_VALID = 1'b1;
        bus.KEY       = k;
        @(negedge CLK);
        bus.KEY_VALID = 1'b0;
        bus.KEY       = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        bus.KEY_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        bus.KEY_VALID = 1'b0;
        bus.KEY       = 4'h0;
        do_reset();
        checks++; if (bus.PIN   !== 5'd0) begin failures++; $display("FAIL reset_pin got=%0d exp=0", bus.PIN); end
        checks++; if (bus.VAL   !== 5'd0) begin failures++; $display("FAIL reset_val got=%0d exp=0", bus.VAL); end
        checks++; if (bus.COD   !== 6'd0) begin failures++; $display("FAIL reset_cod got=%0d exp=0", bus.COD); end
        checks++; if (bus.EN    !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", bus.EN); end
        checks++; if (bus.ERR   !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.ERR); end
        checks++; if (bus.FIELD !== 2'd0) begin failures++; $display("FAIL reset_field got=%0d exp=0", bus.FIELD); end
        checks++; if (bus.ACC   !== 7'd0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", bus.ACC); end
    endtask

    task automatic test_commit();
        key(4'd1); key(4'd2); key(KEY_OK);
        key(4'd1); key(4'd5); key(KEY_OK);
        key(4'd4); key(4'd2);
        checks++; if (bus.ACC !== 7'd42) begin failures++; $display("FAIL commit_acc42 got=%0d exp=42", bus.ACC); end
        checks++; if (bus.EN !== 1'b0 || bus.PIN !== 5'd0) begin failures++; $display("FAIL commit_early en=%b pin=%0d exp en=0 pin=0", bus.EN, bus.PIN); end
        key(KEY_OK);
        checks++; if (bus.EN  !== 1'b1)  begin failures++; $display("FAIL commit_en got=%b exp=1", bus.EN); end
        checks++; if (bus.PIN !== 5'd12) begin failures++; $display("FAIL commit_pin got=%0d exp=12", bus.PIN); end
        checks++; if (bus.VAL !== 5'd15) begin failures++; $display("FAIL commit_val got=%0d exp=15", bus.VAL); end
        checks++; if (bus.COD !== 6'd42) begin failures++; $display("FAIL commit_cod got=%0d exp=42", bus.COD); end
        checks++; if (bus.FIELD !== 2'd0 || bus.ACC !== 7'd0 || bus.ERR !== 1'b0) begin failures++; $display("FAIL commit_state field=%0d acc=%0d err=%b exp 0/0/0", bus.FIELD, bus.ACC, bus.ERR); end
        @(negedge CLK);
        checks++; if (bus.EN !== 1'b0) begin failures++; $display("FAIL commit_en_pulse got=%b exp=0", bus.EN); end
        checks++; if (bus.PIN !== 5'd12 || bus.VAL !== 5'd15 || bus.COD !== 6'd42) begin failures++; $display("FAIL commit_hold pin=%0d val=%0d cod=%0d exp 12/15/42", bus.PIN, bus.VAL, bus.COD); end
    endtask

    task automatic test_range();
        key(4'd3); key(4'd5); key(KEY_OK);
        checks++; if (bus.ERR !== 1'b1 || bus.EN !== 1'b0) begin failures++; $display("FAIL range_err err=%b en=%b exp 1/0", bus.ERR, bus.EN); end
        checks++; if (bus.ACC !== 7'd0 || bus.FIELD !== 2'd0) begin failures++; $display("FAIL range_state acc=%0d field=%0d exp 0/0", bus.ACC, bus.FIELD); end
        checks++; if (bus.PIN !== 5'd12) begin failures++; $display("FAIL range_pin got=%0d exp=12", bus.PIN); end
        @(negedge CLK);
        checks++; if (bus.ERR !== 1'b0) begin failures++; $display("FAIL range_err_pulse got=%b exp=0", bus.ERR); end
    endtask

    task automatic test_digit_cap();
        key(4'd1); key(KEY_OK); key(4'd2); key(KEY_OK);
        key(4'd9); key(4'd9); key(4'd9);
        checks++; if (bus.ACC !== 7'd99 || bus.FIELD !== 2'd2) begin failures++; $display("FAIL cap_acc acc=%0d field=%0d exp 99/2", bus.ACC, bus.FIELD); end
        key(KEY_OK);
        checks++; if (bus.ERR !== 1'b1 || bus.ACC !== 7'd0 || bus.FIELD !== 2'd2) begin failures++; $display("FAIL cap_err err=%b acc=%0d field=%0d exp 1/0/2", bus.ERR, bus.ACC, bus.FIELD); end
        key(4'd6); key(4'd3); key(KEY_OK);
        checks++; if (bus.EN !== 1'b1 || bus.COD !== 6'd63 || bus.PIN !== 5'd1 || bus.VAL !== 5'd2) begin failures++; $display("FAIL cap_commit en=%b pin=%0d val=%0d cod=%0d exp 1/1/2/63", bus.EN, bus.PIN, bus.VAL, bus.COD); end
    endtask

    task automatic test_clr_back();
        key(KEY_OK);
        checks++; if (bus.ERR !== 1'b1 || bus.FIELD !== 2'd0 || bus.EN !== 1'b0) begin failures++; $display("FAIL empty_ok err=%b field=%0d en=%b exp 1/0/0", bus.ERR, bus.FIELD, bus.EN); end
        key(4'd4); key(KEY_OK);
        key(4'd5); key(KEY_CLR);
        checks++; if (bus.ACC !== 7'd0 || bus.FIELD !== 2'd1) begin failures++; $display("FAIL clr_digits acc=%0d field=%0d exp 0/1", bus.ACC, bus.FIELD); end
        key(KEY_CLR);
        checks++; if (bus.FIELD !== 2'd0) begin failures++; $display("FAIL clr_back got=%0d exp=0", bus.FIELD); end
        key(KEY_CLR);
        checks++; if (bus.FIELD !== 2'd0 || bus.ERR !== 1'b0) begin failures++; $display("FAIL clr_pin_noop field=%0d err=%b exp 0/0", bus.FIELD, bus.ERR); end
        key(KEY_OK);
        checks++; if (bus.ERR !== 1'b1) begin failures++; $display("FAIL clr_then_ok got=%b exp=1", bus.ERR); end
        key(4'd7); key(KEY_OK);
        checks++; if (bus.FIELD !== 2'd1) begin failures++; $display("FAIL clr_reenter got=%0d exp=1", bus.FIELD); end
        key(4'd3); key(KEY_OK); key(4'd8); key(KEY_OK);
        checks++; if (bus.EN !== 1'b1 || bus.PIN !== 5'd7 || bus.VAL !== 5'd3 || bus.COD !== 6'd8) begin failures++; $display("FAIL clr_commit en=%b pin=%0d val=%0d cod=%0d exp 1/7/3/8", bus.EN, bus.PIN, bus.VAL, bus.COD); end
    endtask

    task automatic test_rst_mid();
        key(4'd1); key(4'd2); key(KEY_OK); key(4'd1); key(4'd5); key(KEY_OK); key(4'd4); key(4'd2); key(KEY_OK);
        key(4'd2); key(KEY_OK); key(4'd3); key(KEY_OK); key(4'd5);
        @(negedge CLK);
        RST = 1'b1;
        bus.KEY_VALID = 1'b1;
        bus.KEY = KEY_OK;
        @(negedge CLK);
        bus.KEY_VALID = 1'b0;
        RST = 1'b0;
        checks++; if (bus.PIN !== 5'd0 || bus.VAL !== 5'd0 || bus.COD !== 6'd0) begin failures++; $display("FAIL rst_outputs pin=%0d val=%0d cod=%0d exp 0/0/0", bus.PIN, bus.VAL, bus.COD); end
        checks++; if (bus.EN !== 1'b0 || bus.ERR !== 1'b0 || bus.FIELD !== 2'd0 || bus.ACC !== 7'd0) begin failures++; $display("FAIL rst_state en=%b err=%b field=%0d acc=%0d exp 0/0/0/0", bus.EN, bus.ERR, bus.FIELD, bus.ACC); end
        key(4'd9); key(KEY_OK); key(4'd9); key(KEY_OK); key(4'd9); key(KEY_OK);
        checks++; if (bus.PIN !== 5'd9 || bus.VAL !== 5'd9 || bus.COD !== 6'd9) begin failures++; $display("FAIL rst_shadows pin=%0d val=%0d cod=%0d exp 9/9/9", bus.PIN, bus.VAL, bus.COD); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [5];
        seq = '{4'd1, 4'hD, 4'd0, 4'hF, KEY_OK};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            bus.KEY_VALID = 1'b1;
            bus.KEY = seq[i];
        end
        @(negedge CLK);
        bus.KEY_VALID = 1'b0;
        checks++; if (bus.FIELD !== 2'd1 || bus.ACC !== 7'd0 || bus.ERR !== 1'b0) begin failures++; $display("FAIL b2b_field field=%0d acc=%0d err=%b exp 1/0/0", bus.FIELD, bus.ACC, bus.ERR); end
        key(4'd3); key(KEY_OK); key(4'd4); key(KEY_OK);
        checks++; if (bus.PIN !== 5'd10 || bus.VAL !== 5'd3 || bus.COD !== 6'd4) begin failures++; $display("FAIL b2b_shadow pin=%0d val=%0d cod=%0d exp 10/3/4", bus.PIN, bus.VAL, bus.COD); end
    endtask

    task automatic test_random();
        int r, k, kv, rs, bad;
        do_reset();
        model_reset();
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 99);
            kv = ($urandom_range(0, 3) != 0) ? 1 : 0;
            rs = ($urandom_range(0, 199) == 0) ? 1 : 0;
            if (r < 50)      k = $urandom_range(0, 9);
            else if (r < 75) k = 11;
            else if (r < 87) k = 10;
            else             k = $urandom_range(12, 15);
            bus.KEY_VALID = (kv != 0);
            bus.KEY = 4'(k);
            RST = (rs != 0);
            m_en = 0; m_err = 0;
            if (rs != 0) model_reset();
            else if (kv != 0) model_key(k);
            @(negedge CLK);
            RST = 1'b0;
            checks++;
            if (bus.PIN !== 5'(m_pin) || bus.VAL !== 5'(m_val) || bus.COD !== 6'(m_cod) ||
                bus.EN !== 1'(m_en) || bus.ERR !== 1'(m_err) ||
                bus.FIELD !== 2'(m_f) || bus.ACC !== 7'(m_acc)) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random_step i=%0d got pin=%0d val=%0d cod=%0d en=%b err=%b field=%0d acc=%0d exp %0d/%0d/%0d/%0d/%0d/%0d/%0d",
                             i, bus.PIN, bus.VAL, bus.COD, bus.EN, bus.ERR, bus.FIELD, bus.ACC,
                             m_pin, m_val, m_cod, m_en, m_err, m_f, m_acc);
                bad++;
            end
        end
        bus.KEY_VALID = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commit();
        test_range();
        test_digit_cap();
        test_clr_back();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached exp=finish");
        $fatal(1, "timeout");
    end

endmodule
